// File: rtl/psubsb_pkg.sv
// Shared constants and FSM state encoding for the sequential saturating
// packed-nibble subtractor.
package psubsb_pkg;

    localparam int unsigned LANE_W    = 4;
    localparam int unsigned NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

endpackage

// File: rtl/psubsb_seq_nibble_sub_sat.sv
// One signed lane of a - b with saturation to the lane's signed range.
module nibble_sub_sat
    import psubsb_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] d,
    output logic              ovf
);

    logic [LANE_W:0] diff_wide;

    always_comb begin
        diff_wide = {a[LANE_W-1], a} - {b[LANE_W-1], b};
        // Sign-extended result disagreeing with its truncated sign is exactly
        // the "operand signs differ and result sign flipped" overflow case.
        ovf = diff_wide[LANE_W] != diff_wide[LANE_W-1];
        d   = ovf ? (a[LANE_W-1] ? SAT_NEG : SAT_POS) : diff_wide[LANE_W-1:0];
    end

endmodule

// File: rtl/psubsb_seq.sv
// Sequential packed saturating subtract, one lane per cycle.
// Optional per-lane saturation flags via macro PSUBSB_SAT_FLAGS_EN.
module psubsb_seq #(
    parameter int unsigned LANE_W    = psubsb_pkg::LANE_W,
    parameter int unsigned NUM_LANES = psubsb_pkg::NUM_LANES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LANE_W*NUM_LANES-1:0] A,
    input  logic [LANE_W*NUM_LANES-1:0] B,
    output logic                        busy,
    output logic                        done,
    output logic [LANE_W*NUM_LANES-1:0] Diff
`ifdef PSUBSB_SAT_FLAGS_EN
    ,
    output logic [NUM_LANES-1:0]        sat
`endif
);

    import psubsb_pkg::*;

    localparam int unsigned OP_W  = LANE_W * NUM_LANES;
    localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx;
    logic [OP_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]   acc, acc_next;
    logic [LANE_W-1:0] lane_a, lane_b, lane_d;
    logic              lane_ovf;
    logic              accept;
    logic              last_lane;

    assign lane_a    = a_q[idx*LANE_W +: LANE_W];
    assign lane_b    = b_q[idx*LANE_W +: LANE_W];
    assign last_lane = (idx == IDX_W'(NUM_LANES - 1));

    nibble_sub_sat u_lane (
        .a   (lane_a),
        .b   (lane_b),
        .d   (lane_d),
        .ovf (lane_ovf)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        acc_next = acc;
        acc_next[idx*LANE_W +: LANE_W] = lane_d;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_lane) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            Diff    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= A;
                b_q <= B;
                idx <= '0;
            end else if (state_q == RUN) begin
                acc <= acc_next;
                idx <= idx + IDX_W'(1);
                // Publish the merged value so the final lane lands on the same edge.
                if (last_lane) Diff <= acc_next;
            end
        end
    end

`ifdef PSUBSB_SAT_FLAGS_EN
    logic [NUM_LANES-1:0] sat_acc, sat_acc_next;

    always_comb begin
        sat_acc_next      = sat_acc;
        sat_acc_next[idx] = lane_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_acc <= '0;
            sat     <= '0;
        end else if (!accept && state_q == RUN) begin
            sat_acc <= sat_acc_next;
            if (last_lane) sat <= sat_acc_next;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = lane_ovf;
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_psubsb_seq.sv
// Self-checking bench for psubsb_seq: vector table, scoreboard, and
// hand-written back-to-back / ignored-start / reset sequences.
module tb_psubsb_seq;

    typedef struct {
        logic [15:0] diff;
        logic [3:0]  sat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic [3:0]  sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A, B;
    logic        busy, done;
    logic [15:0] Diff;
`ifdef PSUBSB_SAT_FLAGS_EN
    logic [3:0]  sat;
`endif

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    exp_t sb[$];

    psubsb_seq #(.LANE_W(4), .NUM_LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff)
`ifdef PSUBSB_SAT_FLAGS_EN
        ,
        .sat   (sat)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent integer reference: clamp the true difference to [-8,7].
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        logic signed [3:0] la, lb;
        int d;
        r.diff = '0;
        r.sat  = '0;
        for (int i = 0; i < 4; i++) begin
            la = a[i*4 +: 4];
            lb = b[i*4 +: 4];
            d  = int'(la) - int'(lb);
            if (d > 7) begin
                d = 7;
                r.sat[i] = 1'b1;
            end else if (d < -8) begin
                d = -8;
                r.sat[i] = 1'b1;
            end
            r.diff[i*4 +: 4] = d[3:0];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Diff=%h expected no done", Diff);
            end else begin
                e = sb.pop_front();
                chk("diff", 32'(Diff), 32'(e.diff));
`ifdef PSUBSB_SAT_FLAGS_EN
                chk("sat", 32'(sat), 32'(e.sat));
`endif
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic [3:0] es);
        exp_t e;
        int cyc, bc;
        e.diff = ed;
        e.sat  = es;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        bc = 0;
        while (!done && cyc < 20) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd4);
        chk("busy_cycles", 32'(bc), 32'd4);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("diff_hold", 32'(Diff), 32'(ed));
    endtask

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int cyc, dc;

        vecs[0]  = '{16'h7830, 16'h8150, 16'h78E0, 4'b1100};
        vecs[1]  = '{16'h1234, 16'h1111, 16'h0123, 4'b0000};
        vecs[2]  = '{16'h8888, 16'h1111, 16'h8888, 4'b1111};
        vecs[3]  = '{16'h0000, 16'h8888, 16'h7777, 4'b1111};
        vecs[4]  = '{16'h7777, 16'h8888, 16'h7777, 4'b1111};
        vecs[5]  = '{16'h8888, 16'h7777, 16'h8888, 4'b1111};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000};
        vecs[7]  = '{16'h0000, 16'h0001, 16'h000F, 4'b0000};
        vecs[8]  = '{16'h7000, 16'hF000, 16'h7000, 4'b1000};
        vecs[9]  = '{16'h8000, 16'h1000, 16'h8000, 4'b1000};
        vecs[10] = '{16'h1234, 16'h4321, 16'hDF13, 4'b0000};

        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(Diff), 32'd0);
`ifdef PSUBSB_SAT_FLAGS_EN
        chk("reset_sat", 32'(sat), 32'd0);
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].sat);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            e = model(ra, rb);
            do_op(ra, rb, e.diff, e.sat);
        end

        // Start held high: back-to-back operations every 5 cycles.
        e.diff = 16'h8888;
        e.sat  = 4'b1111;
        @(negedge clk);
        A = 16'h8888;
        B = 16'h1111;
        start = 1'b1;
        repeat (3) sb.push_back(e);
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            cyc = 0;
            if (n > 0) begin
                @(posedge clk);
                #1;
                cyc = 1;
            end
            while (!done && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("b2b_period", 32'(cyc), (n == 0) ? 32'd4 : 32'd5);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // Start pulsed during RUN with other operands must be ignored.
        dc = done_count;
        e.diff = 16'h0123;
        e.sat  = 4'b0000;
        @(negedge clk);
        A = 16'h1234;
        B = 16'h1111;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        A = 16'h7777;
        B = 16'h8888;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ignored_start_dones", 32'(done_count - dc), 32'd1);
        chk("ignored_start_sb", 32'(sb.size()), 32'd0);
        chk("ignored_start_diff", 32'(Diff), 32'h0123);

        // Reset in the second RUN cycle clears everything immediately.
        e.diff = 16'h78E0;
        e.sat  = 4'b1100;
        @(negedge clk);
        A = 16'h7830;
        B = 16'h8150;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_done", 32'(done), 32'd0);
        chk("midrun_rst_diff", 32'(Diff), 32'd0);
`ifdef PSUBSB_SAT_FLAGS_EN
        chk("midrun_rst_sat", 32'(sat), 32'd0);
`endif
        sb.delete();
        dc = done_count;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_rst", 32'(done_count - dc), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);

        // Start on the first edge after reset release is accepted.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        do_op(16'h0000, 16'h8888, 16'h7777, 4'b1111);

        repeat (2) @(posedge clk);
        #2;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
